// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and sizing helpers for the serial add/sub unit.
//   state_t      - controller states (IDLE, RUN, DONE)
//   nchunk()     - number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_width()  - width of the chunk index counter, never below 1 bit
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple-carry adder slice.
//   a, b      - CHUNK-bit addends
//   cin       - carry into bit 0
//   s         - CHUNK-bit sum
//   cout      - carry out of the top bit
//   c_msb_in  - carry into the top bit (signed overflow = c_msb_in ^ cout)
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        c        = cin;
        c_msb_in = 1'b0;
        s        = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle two's-complement add/subtract unit.
// CHUNK bits are added per clock, so a WIDTH-bit operation takes WIDTH/CHUNK
// RUN cycles followed by a single DONE cycle.
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   start     - request, accepted only while ready=1
//   sub       - 0: X+Y, 1: X-Y (sampled with start)
//   acc       - 1: use current z as X instead of x (sampled with start)
//   x, y      - WIDTH-bit operands
//   ready     - high in IDLE
//   done      - one-cycle pulse when z and flags are updated
//   z         - registered result, held until the next done
//   carry     - carry out of the MSB (for sub: 1 = no borrow)
//   overflow  - signed overflow
//   zero      - z == 0
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int KW     = cnt_width(NCHUNK);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and CHUNK >= 1 must divide WIDTH");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-1:0] part, part_n;
    logic [KW-1:0]    k;
    logic             rc;
    logic             last;

    logic [CHUNK-1:0] a_ch, b_ch, s_ch;
    logic             cout_ch, cmsb_ch;

    assign last = (k == KW'(NCHUNK - 1));

    always_comb begin
        a_ch = opa[int'(k)*CHUNK +: CHUNK];
        b_ch = opb[int'(k)*CHUNK +: CHUNK];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_ch),
        .b        (b_ch),
        .cin      (rc),
        .s        (s_ch),
        .cout     (cout_ch),
        .c_msb_in (cmsb_ch)
    );

    // Partial result with the current chunk merged in; on the last chunk this
    // is the complete result, so z/zero can be loaded on the same edge.
    always_comb begin
        part_n = part;
        part_n[int'(k)*CHUNK +: CHUNK] = s_ch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            part     <= '0;
            k        <= '0;
            rc       <= 1'b0;
            z        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa  <= acc ? z : x;
                        // Subtraction as X + ~Y + 1, the +1 entering as carry-in.
                        opb  <= sub ? ~y : y;
                        rc   <= sub;
                        k    <= '0;
                        part <= '0;
                    end
                end
                RUN: begin
                    part <= part_n;
                    rc   <= cout_ch;
                    if (last) begin
                        k        <= '0;
                        z        <= part_n;
                        carry    <= cout_ch;
                        overflow <= cmsb_ch ^ cout_ch;
                        zero     <= (part_n == '0);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: self-checking bench for serial_addsub (WIDTH=16, CHUNK=4).
module tb_serial_addsub;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NC = W / C;

    logic         clk = 1'b0;
    logic         rst, start, sub, acc;
    logic [W-1:0] x, y;
    logic         ready, done, carry, overflow, zero;
    logic [W-1:0] z;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] mz;  // reference model's view of z

    serial_addsub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .acc      (acc),
        .x        (x),
        .y        (y),
        .ready    (ready),
        .done     (done),
        .z        (z),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic         a;
        logic [W-1:0] ez;
        logic         ec;
        logic         eo;
        logic         ezr;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
    } pend_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] rz, output logic rc, output logic rv,
                          output logic rzr);
        longint ua, ub, sa, sb, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            rz = a - b;
            rc = (ua >= ub);
            sr = sa - sb;
        end else begin
            rz = a + b;
            rc = ((ua + ub) >= (longint'(1) << W));
            sr = sa + sb;
        end
        rv  = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
        rzr = (rz == '0);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic sv, input logic av, input logic [W-1:0] ez,
                          input logic ec, input logic eo, input logic ezr);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready"}, 32'(ready), 32'd1);
        x = xv; y = yv; sub = sv; acc = av; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x = W'($urandom); y = W'($urandom); sub = 1'($urandom); acc = 1'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(NC));
        chk({nm, " z"}, 32'(z), 32'(ez));
        chk({nm, " carry"}, 32'(carry), 32'(ec));
        chk({nm, " overflow"}, 32'(overflow), 32'(eo));
        chk({nm, " zero"}, 32'(zero), 32'(ezr));
        mz = ez;
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(done), 32'd0);
        chk({nm, " ready after"}, 32'(ready), 32'd1);
        chk({nm, " z held"}, 32'(z), 32'(ez));
    endtask

    function automatic vec_t mk(input string nm, input logic [W-1:0] xv, input logic [W-1:0] yv,
                                input logic sv, input logic av, input logic [W-1:0] ez,
                                input logic ec, input logic eo, input logic ezr);
        vec_t v;
        v.nm = nm; v.x = xv; v.y = yv; v.s = sv; v.a = av;
        v.ez = ez; v.ec = ec; v.eo = eo; v.ezr = ezr;
        return v;
    endfunction

    initial begin
        vec_t  tbl[$];
        pend_t pq[$];
        pend_t p;
        logic [W-1:0] rz, a_eff;
        logic rc, rv, rzr, prev_done;
        int acc_cnt, last_acc, ndone;

        rst = 1'b1; start = 1'b0; sub = 1'b0; acc = 1'b0; x = '0; y = '0;
        mz = '0;
        repeat (2) @(negedge clk);
        chk("reset z", 32'(z), 32'd0);
        chk("reset flags", {29'd0, carry, overflow, zero}, 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", 32'(ready), 32'd1);

        tbl.push_back(mk("add",       16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("sub borrow",16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("add ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk("sub ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("wrap zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk("sub y=0",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk("sub y=min", 16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk("min+min",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk("acc seed",  16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("acc add",   16'hAAAA, 16'h0003, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            run_op(tbl[i].nm, tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].a,
                   tbl[i].ez, tbl[i].ec, tbl[i].eo, tbl[i].ezr);
        end

        // Start asserted every cycle: accepts must be NC+2 apart, results must
        // match operands present at each accept edge.
        acc_cnt = 0; last_acc = -1; prev_done = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done === 1'b1) begin
                chk("no double done", 32'(prev_done), 32'd0);
                if (pq.size() == 0) begin
                    chk("hs unexpected done", 32'd1, 32'd0);
                end else begin
                    p = pq.pop_front();
                    ref_op(p.a, p.b, p.s, rz, rc, rv, rzr);
                    chk("hs z", 32'(z), 32'(rz));
                    chk("hs flags", {29'd0, carry, overflow, zero}, {29'd0, rc, rv, rzr});
                    mz = rz;
                end
            end
            prev_done = done;
            if (cyc < 20) begin
                x = W'($urandom); y = W'($urandom); sub = 1'($urandom); acc = 1'($urandom);
                start = 1'b1;
                if (ready === 1'b1) begin
                    if (last_acc >= 0) chk("hs spacing", 32'(cyc - last_acc), 32'(NC + 2));
                    last_acc = cyc;
                    acc_cnt++;
                    p.a = acc ? mz : x;
                    p.b = y;
                    p.s = sub;
                    pq.push_back(p);
                end
            end else begin
                start = 1'b0;
            end
        end
        chk("hs accept count", 32'(acc_cnt), 32'd4);
        chk("hs all completed", 32'(pq.size()), 32'd0);

        // Reset two cycles into an operation.
        run_op("pre-reset", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        x = 16'h1234; y = 16'h1111; sub = 1'b0; acc = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst ready", 32'(ready), 32'd1);
        chk("midrst z", 32'(z), 32'd0);
        chk("midrst flags", {29'd0, carry, overflow, zero}, 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mz = '0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("midrst no done", 32'(ndone), 32'd0);
        run_op("post-reset acc", 16'hFFFF, 16'h0005, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);

        // Randomised operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] xv, yv;
            logic sv, av;
            xv = W'($urandom); yv = W'($urandom);
            sv = 1'($urandom); av = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: yv = '0;
                1: yv = 16'h8000;
                2: xv = 16'h7FFF;
                3: yv = xv;
                default: ;
            endcase
            a_eff = av ? mz : xv;
            ref_op(a_eff, yv, sv, rz, rc, rv, rzr);
            run_op("rand", xv, yv, sv, av, rz, rc, rv, rzr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
